pixel_sink: RTL and testbench

Receiving end of the pixel stream produced by the drawing core (x, y, 9-bit colour). Buffers incoming pixels in a small FIFO, range-checks them against the 160x120 screen, converts each to a linear framebuffer address and writes it through a single-port memory write handshake. Also performs a full-screen clear to a given colour on request, so the game core can wipe the grill between rounds.

---
 rtl/pixel_sink_if.sv | 23 ++
 rtl/pixel_sink.sv | 156 +++++++++++++++
 tb/tb_pixel_sink.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_sink_if.sv
// Pixel stream input and framebuffer write port of the pixel sink.
// master = stream source / memory side, slave = the sink.
interface pixel_sink_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [8:0]  in_colour;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [8:0]  mem_data;
    logic        mem_ack;

    modport master (
        output in_valid, in_x, in_y, in_colour, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour, mem_ack,
        output in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/pixel_sink.sv
// Range-checks pixels, queues them and writes them to the framebuffer; write appears the cycle after accept.
// in_ready is registered and drops when the FIFO fills or a clear is pending/running; the full-screen clear sweeps 0..X_MAX*Y_MAX-1.
module pixel_sink #(
    parameter int unsigned X_MAX = 160,
    parameter int unsigned Y_MAX = 120,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    pixel_sink_if.slave      bus,
    input  logic             clear_req,
    input  logic [8:0]       clear_colour,
    output logic             busy,
    output logic [7:0]       dropped_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [14:0]  LAST_ADDR = 15'(X_MAX * Y_MAX - 1);
    localparam logic [7:0]   X_LIM     = 8'(X_MAX);
    localparam logic [7:0]   Y_LIM     = 8'(Y_MAX);

    typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [14:0]   fifo_addr [DEPTH];
    logic [8:0]    fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          we, we_nxt;
    logic [14:0]   addr, addr_nxt;
    logic [8:0]    data, data_nxt;
    logic          clr_pend, clr_pend_nxt;
    logic [8:0]    clr_col, clr_col_nxt;
    logic [7:0]    drop_cnt, drop_cnt_nxt;
    logic          rdy, rdy_nxt;

    logic          accept, in_range, fifo_empty, slot_free, enter_clear, load, push, pop;
    logic [14:0]   in_addr, head_addr;
    logic [8:0]    head_data;

    always_comb begin
        accept      = bus.in_valid && rdy;
        in_range    = (bus.in_x < X_LIM) && (bus.in_y < Y_LIM);
        in_addr     = {bus.in_y, 7'b0} + {2'b0, bus.in_y, 5'b0} + {7'b0, bus.in_x};
        fifo_empty  = (count == '0);
        slot_free   = !we || bus.mem_ack;
        enter_clear = clr_pend && fifo_empty && slot_free && (state != CLEAR);
        // An empty FIFO lets the incoming pixel go straight into the write slot.
        load        = slot_free && (state != CLEAR) && !enter_clear
                      && (!fifo_empty || (accept && in_range));
        pop         = load && !fifo_empty;
        push        = accept && in_range && !(load && fifo_empty);
        head_addr   = fifo_empty ? in_addr : fifo_addr[rd_ptr];
        head_data   = fifo_empty ? bus.in_colour : fifo_data[rd_ptr];

        wr_ptr_nxt  = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_nxt  = pop  ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt   = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (AW+1)'(1);

        clr_pend_nxt = clr_pend;
        clr_col_nxt  = clr_col;
        if (clear_req && !clr_pend && (state != CLEAR)) begin
            clr_pend_nxt = 1'b1;
            clr_col_nxt  = clear_colour;
        end

        we_nxt    = we;
        addr_nxt  = addr;
        data_nxt  = data;
        state_nxt = state;
        case (state)
            CLEAR: begin
                if (bus.mem_ack) begin
                    if (addr == LAST_ADDR) begin
                        we_nxt       = 1'b0;
                        clr_pend_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        addr_nxt = addr + 15'd1;
                    end
                end
            end
            default: begin
                if (enter_clear) begin
                    we_nxt   = 1'b1;
                    addr_nxt = '0;
                    data_nxt = clr_col;
                end else if (load) begin
                    we_nxt   = 1'b1;
                    addr_nxt = head_addr;
                    data_nxt = head_data;
                end else if (bus.mem_ack) begin
                    we_nxt = 1'b0;
                end
                if (enter_clear)
                    state_nxt = CLEAR;
                else if ((count_nxt != '0) || we_nxt)
                    state_nxt = STREAM;
                else
                    state_nxt = IDLE;
            end
        endcase

        drop_cnt_nxt = drop_cnt;
        if (accept && !in_range && (drop_cnt != 8'hFF))
            drop_cnt_nxt = drop_cnt + 8'd1;

        rdy_nxt = (count_nxt != CNT_FULL) && !clr_pend_nxt && (state_nxt != CLEAR);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            we       <= 1'b0;
            addr     <= '0;
            data     <= '0;
            clr_pend <= 1'b0;
            clr_col  <= '0;
            drop_cnt <= '0;
            rdy      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            we       <= we_nxt;
            addr     <= addr_nxt;
            data     <= data_nxt;
            clr_pend <= clr_pend_nxt;
            clr_col  <= clr_col_nxt;
            drop_cnt <= drop_cnt_nxt;
            rdy      <= rdy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn && push) begin
            fifo_addr[wr_ptr] <= in_addr;
            fifo_data[wr_ptr] <= bus.in_colour;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr;
    assign bus.mem_data  = data;
    assign busy          = (count != '0) || we || clr_pend || (state == CLEAR);
    assign dropped_count = drop_cnt;
endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: expected writes queued at accept/clear time, compared as the memory acks them.
module tb_pixel_sink;
    logic       clk = 1'b0;
    logic       resetn;
    logic       clear_req;
    logic [8:0] clear_colour;
    logic       busy;
    logic [7:0] dropped_count;

    pixel_sink_if bus();

    pixel_sink #(.X_MAX(160), .Y_MAX(120), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .clear_req(clear_req),
        .clear_colour(clear_colour), .busy(busy), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    int          ack_mode = 0;
    bit          sb_en = 1'b1;
    bit          hold_v = 1'b0;
    logic [23:0] hold_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] lin(input int x, input int y);
        return 15'(y * 160 + x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [8:0] c);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'(x);
        bus.in_y      = 8'(y);
        bus.in_colour = c;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 0, 1);
        if (x < 160 && y < 120) exp_q.push_back({lin(x, y), c});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.mem_we || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 500), 1);
        check("sb_empty", exp_q.size(), 0);
    endtask

    // Memory model: ack pattern driven just after each rising edge.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus.mem_ack = 1'b1;
                1:       bus.mem_ack = 1'b0;
                default: bus.mem_ack = ~bus.mem_ack;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (bus.mem_we && sb_en) begin
            if (hold_v) begin
                check("hold_addr", 32'(bus.mem_addr), 32'(hold_w[23:9]));
                check("hold_data", 32'(bus.mem_data), 32'(hold_w[8:0]));
            end
            if (bus.mem_ack) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e[23:9]));
                    check("wr_data", 32'(bus.mem_data), 32'(e[8:0]));
                end
            end else begin
                hold_v = 1'b1;
                hold_w = {bus.mem_addr, bus.mem_data};
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int n;
        resetn        = 1'b1;
        clear_req     = 1'b0;
        clear_colour  = '0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_colour = '0;
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_data", 32'(bus.mem_data), 0);
        check("rst_dropped", 32'(dropped_count), 0);
        check("rst_busy", busy, 0);
        resetn = 1'b0;
        tick();
        check("ready_after_rst", bus.in_ready, 1);
        repeat (2) tick();

        // Single pixel, write visible the cycle after accept
        send(10, 2, 9'h1C0);
        check("single_we", bus.mem_we, 1);
        check("single_addr", 32'(bus.mem_addr), 330);
        check("single_data", 32'(bus.mem_data), 32'h1C0);
        tick();
        check("single_busy", busy, 0);
        wait_idle();

        // Burst with memory stalled: 1 outstanding + DEPTH buffered
        ack_mode = 1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) send(i * 3, i + 1, 9'(i + 1));
        check("burst_full_ready", bus.in_ready, 0);
        fork
            send(50, 60, 9'h0F0);
            begin
                repeat (10) tick();
                ack_mode = 0;
            end
        join
        wait_idle();

        // Out-of-range pixels and the last in-range corner
        send(160, 0, 9'h001);
        send(0, 120, 9'h002);
        tick();
        check("drop_two", 32'(dropped_count), 2);
        check("drop_no_write", bus.mem_we, 0);
        send(159, 119, 9'h155);
        wait_idle();
        for (int i = 0; i < 300; i++) send(200, 200, 9'h003);
        tick();
        check("drop_saturate", 32'(dropped_count), 255);

        // Ack toggling every other cycle
        ack_mode = 2;
        for (int i = 0; i < 6; i++) send(i * 20, i * 15, 9'(i * 50));
        wait_idle();
        ack_mode = 0;
        repeat (2) tick();

        // Clear with two pixels still buffered; a second clear_req must be ignored
        ack_mode = 1;
        repeat (2) tick();
        send(5, 5, 9'h0AA);
        send(6, 5, 9'h055);
        clear_req    = 1'b1;
        clear_colour = 9'h000;
        for (int a = 0; a < 19200; a++) exp_q.push_back({15'(a), 9'h000});
        tick();
        clear_req = 1'b0;
        check("clear_ready_low", bus.in_ready, 0);
        ack_mode = 0;
        saw = 1'b0;
        n = 0;
        while (busy && n < 21000) begin
            clear_req    = (n == 50);
            clear_colour = 9'h1FF;
            tick();
            if (bus.in_ready && busy) saw = 1'b1;
            n++;
        end
        clear_req = 1'b0;
        check("clear_timeout", 32'(n < 21000), 1);
        check("clear_ready_held", saw, 0);
        check("clear_sb_empty", exp_q.size(), 0);
        tick();
        check("clear_ready_after", bus.in_ready, 1);

        // Reset in the middle of a clear
        sb_en        = 1'b0;
        clear_req    = 1'b1;
        clear_colour = 9'h1FF;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (n < 6000) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_addr == 15'd5000) break;
            n++;
        end
        check("reach_5000", 32'(n < 6000), 1);
        resetn = 1'b1;
        tick();
        check("midrst_we", bus.mem_we, 0);
        check("midrst_addr", 32'(bus.mem_addr), 0);
        check("midrst_data", 32'(bus.mem_data), 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.in_ready, 0);
        check("midrst_dropped", 32'(dropped_count), 0);
        resetn = 1'b0;
        tick();
        check("midrst_ready_after", bus.in_ready, 1);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mem_we || busy) saw = 1'b1;
        end
        check("no_clear_resume", saw, 0);
        sb_en = 1'b1;
        send(0, 0, 9'h1FF);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
